// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - run-time programmable multi-channel clock-enable (tick) generator
module clk_tick_gen #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int DIV_RESET = 5,
  parameter int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 reset,
  input  logic                 clock,
  input  logic                 sync,
  input  logic                 cfg_valid,
  input  logic [CHW-1:0]       cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  output logic [CHANNELS-1:0]  pend,
  output logic [CHANNELS-1:0]  tick
);

  logic chan_ok;

  assign chan_ok = (32'(cfg_chan) < CHANNELS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= cfg_valid;
      cfg_err <= cfg_valid && !chan_ok;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] div_r;
    logic [CNT_WIDTH-1:0] shd;
    logic                 pend_r;
    logic                 tick_r;
    logic                 wr;
    logic                 at_bnd;

    assign wr     = cfg_valid && chan_ok && (cfg_chan == CHW'(g));
    assign at_bnd = (div_r != '0) && (cnt == div_r - CNT_WIDTH'(1));
    assign pend[g] = pend_r;
    assign tick[g] = tick_r;

    // Divisor changes only at period boundaries, sync, or while idle, so cnt never exceeds div-1.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        div_r  <= CNT_WIDTH'(DIV_RESET);
        shd    <= CNT_WIDTH'(DIV_RESET);
        pend_r <= 1'b0;
        tick_r <= 1'b0;
      end else if (sync) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        pend_r <= 1'b0;
        if (wr) begin
          div_r <= cfg_div;
          shd   <= cfg_div;
        end else if (pend_r) begin
          div_r <= shd;
        end
      end else if (div_r == '0) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        if (wr) begin
          div_r  <= cfg_div;
          shd    <= cfg_div;
          pend_r <= 1'b0;
        end
      end else if (at_bnd) begin
        cnt    <= '0;
        tick_r <= 1'b1;
        if (wr) begin
          div_r  <= cfg_div;
          shd    <= cfg_div;
          pend_r <= 1'b0;
        end else if (pend_r) begin
          div_r  <= shd;
          pend_r <= 1'b0;
        end
      end else begin
        cnt    <= cnt + CNT_WIDTH'(1);
        tick_r <= 1'b0;
        if (wr) begin
          shd    <= cfg_div;
          pend_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb/tb_clk_tick_gen.sv - randomized and directed check of clk_tick_gen against a countdown model
module tb_clk_tick_gen;

  localparam int NCH = 4;

  logic        reset;
  logic        clock;
  logic        sync;
  logic        cfg_valid;
  logic [2:0]  cfg_chan;
  logic [15:0] cfg_div;
  logic        cfg_ack;
  logic        cfg_err;
  logic [3:0]  pend;
  logic [3:0]  tick;

  int total = 0;
  int bad   = 0;

  // Model: edges remaining until the next tick, current period, shadow period, pending flag.
  int   rem [NCH];
  int   per [NCH];
  int   shdm[NCH];
  bit   pm  [NCH];
  logic [3:0] exp_tick, exp_pend;
  logic       exp_ack, exp_err;

  clk_tick_gen #(.CHANNELS(4), .CNT_WIDTH(16), .DIV_RESET(5), .CHW(3)) dut (
    .reset(reset), .clock(clock), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .pend(pend), .tick(tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      rem[i] = 5; per[i] = 5; shdm[i] = 5; pm[i] = 0;
    end
    exp_tick = '0; exp_pend = '0; exp_ack = 0; exp_err = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input int c, input int d);
    for (int i = 0; i < NCH; i++) begin
      bit w;
      w = v && (c < NCH) && (c == i);
      exp_tick[i] = 1'b0;
      if (s) begin
        if (w) per[i] = d;
        else if (pm[i]) per[i] = shdm[i];
        pm[i] = 0;
        rem[i] = per[i];
      end else if (per[i] == 0) begin
        if (w) begin per[i] = d; rem[i] = d; end
      end else if (rem[i] == 1) begin
        exp_tick[i] = 1'b1;
        if (w) per[i] = d;
        else if (pm[i]) per[i] = shdm[i];
        pm[i] = 0;
        rem[i] = per[i];
      end else begin
        rem[i]--;
        if (w) begin shdm[i] = d; pm[i] = 1; end
      end
      exp_pend[i] = pm[i];
    end
    exp_ack = v;
    exp_err = v && (c >= NCH);
  endtask

  task automatic step(input bit s, input bit v, input int c, input int d);
    sync = s; cfg_valid = v; cfg_chan = 3'(c); cfg_div = 16'(d);
    @(posedge clock);
    model_step(s, v, c, d);
    #1;
    check("tick", 32'(tick), 32'(exp_tick));
    check("pend", 32'(pend), 32'(exp_pend));
    check("ack",  32'(cfg_ack), 32'(exp_ack));
    check("err",  32'(cfg_err), 32'(exp_err));
    sync = 0; cfg_valid = 0; cfg_chan = '0; cfg_div = '0;
  endtask

  initial begin
    int ticks0;
    int guard;
    reset = 0; sync = 0; cfg_valid = 0; cfg_chan = '0; cfg_div = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_tick", 32'(tick), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_ack",  32'(cfg_ack), 0);
    check("rst_err",  32'(cfg_err), 0);
    reset = 1;

    // Reset release: ticks on edges 5, 10, 15.
    ticks0 = 0;
    for (int k = 0; k < 15; k++) begin
      step(0, 0, 0, 0);
      if (tick[0]) ticks0++;
    end
    check("ticks_after_reset", 32'(ticks0), 3);

    // ch1 div=3 written two cycles after a tick.
    step(0, 0, 0, 0);
    step(0, 1, 1, 3);
    repeat (10) step(0, 0, 0, 0);

    // ch2 to 0, wait until idle, then 7.
    step(0, 1, 2, 0);
    repeat (8) step(0, 0, 0, 0);
    step(0, 1, 2, 7);
    repeat (9) step(0, 0, 0, 0);

    // Write exactly on a ch0 boundary.
    guard = 0;
    while (rem[0] != 1 && guard < 20) begin step(0, 0, 0, 0); guard++; end
    check("find_bnd0", 32'(rem[0]), 1);
    step(0, 1, 0, 2);
    repeat (5) step(0, 0, 0, 0);

    // Pending ch3 shadow, then sync with simultaneous ch0 write.
    guard = 0;
    while (rem[3] <= 2 && guard < 20) begin step(0, 0, 0, 0); guard++; end
    step(0, 1, 3, 4);
    check("pend3_set", 32'(pend[3]), 1);
    step(1, 1, 0, 6);
    repeat (8) step(0, 0, 0, 0);

    // Out-of-range channel.
    step(0, 1, 4, 1);
    repeat (3) step(0, 0, 0, 0);

    // Random traffic including back-to-back writes and syncs.
    for (int k = 0; k < 400; k++) begin
      bit s, v;
      int c, d;
      s = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) == 0);
      c = $urandom_range(0, 4);
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9);
      step(s, v, c, d);
    end

    // Mid-period reset drops outputs asynchronously.
    for (int i = 0; i < NCH; i++) step(0, 1, i, 1);
    step(0, 0, 0, 0);
    #2;
    reset = 0;
    #1;
    check("async_tick", 32'(tick), 0);
    check("async_pend", 32'(pend), 0);
    model_reset();
    @(posedge clock);
    #2;
    reset = 1;
    repeat (12) step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Run-time programmable, multi-channel clock-enable generator, replacing the fixed compile-time dividers (cpu, peripheral, rtc, baud). Each channel has a counter that emits a one-cycle `tick` every `div` cycles of the single system clock. Divisors are reprogrammed over a small write port without glitches: a new value takes effect at the channel's next period boundary. A global `sync` input phase-aligns all channels.

## Interface
- `CHANNELS`, 4, number of independent tick channels (≥1)
- `CNT_WIDTH`, 16, divisor and counter width in bits
- `DIV_RESET`, 5, divisor loaded into every channel at reset (sys 100 MHz / cpu 20 MHz)
- `CHW`, derived: max(1, $clog2(CHANNELS)), channel-select width

Ports:
- `reset`  in  1  asynchronous, active-low reset
- `clock`  in  1  system clock; all logic on the rising edge
- `sync`  in  1  global restart of all channel counters
- `cfg_valid`  in  1  single-cycle divisor write strobe
- `cfg_chan`  in  CHW  target channel
- `cfg_div`  in  CNT_WIDTH  new divisor; 0 disables the channel
- `cfg_ack`  out  1  registered pulse one cycle after `cfg_valid`
- `cfg_err`  out  1  pulses with `cfg_ack` when `cfg_chan` ≥ CHANNELS
- `pend`  out  CHANNELS  per channel: shadow divisor written but not yet applied
- `tick`  out  CHANNELS  registered one-cycle clock-enable per channel

## Operation
- Per-channel state: `cnt`, active divisor `div`, shadow `shd`, `pend`.
- Reset (`reset`=0, asynchronous): `cnt`=0, `div`=`shd`=DIV_RESET, `pend`=0, `tick`=0, `cfg_ack`=0, `cfg_err`=0.
- The boundary condition for a channel is `div`≠0 and `cnt`==`div`-1. Each edge evaluates the channel as follows:
  - At a boundary: `cnt`←0, `tick`←1, and if `pend` then `div`←`shd`, `pend`←0.
  - `div`≠0 and not at a boundary: `cnt`←`cnt`+1, `tick`←0.
  - `div`==0 (idle): `cnt` holds 0, `tick`←0.
- A divisor write (`cfg_valid`=1, valid chan) goes to the addressed channel:
  - Active channel, not at a boundary: `shd`←`cfg_div`, `pend`←1. A repeat write while `pend`=1 overwrites `shd`, and the last value wins.
  - Same edge as that channel's boundary: `div`←`cfg_div` directly, `pend`←0. The tick still fires.
  - Idle channel (`div`=0): `div`←`cfg_div`, `cnt`←0, `pend`←0. The first tick follows `cfg_div` edges later.
  - Writing 0 to an active channel completes the current period. At the boundary the channel goes idle. The period's final tick is emitted.
- `cfg_err`: the write is ignored and no channel changes state. `cfg_ack` and `cfg_err` both pulse.
- `sync`=1 (priority over the counting rules) applies to all channels: `cnt`←0, `tick`←0, and any pending `shd` is applied (`pend`←0). A `cfg_valid` in the same cycle is applied directly to `div` of its channel. The next tick of each channel comes `div` edges after the sync edge.
- Arithmetic: `cnt` is unsigned CNT_WIDTH. Because `div`-1 is compared, `cnt` never wraps. `div`=1 ticks every cycle, and `div`=2^CNT_WIDTH-1 is the maximum period.

## Timing
- `tick` period = `div` cycles, duty 1 cycle. With `div`=D from reset release, the first `tick` is high after the D-th rising edge.
- `cfg_ack`/`cfg_err` are high for exactly one cycle, one edge after the `cfg_valid` edge. Back-to-back writes produce back-to-back acks.
- A new divisor affects the period beginning after the next boundary (or immediately, per the rules above). No period shorter than min(old, new) is ever produced.
- `pend` rises the edge after the write and falls on the edge that performs the apply.
- Reset asserted mid-period: all outputs drop asynchronously to their reset values. The first post-reset tick is DIV_RESET edges after release.

## Test plan
- Reset release, CHANNELS=4, DIV_RESET=5 → all `tick` high on edges 5, 10, 15, and `cfg_ack`/`pend` stay 0.
- Write ch1 `div`=3 two cycles after a ch1 tick → `pend[1]`=1 for 3 cycles. The next ch1 tick stays at the old +5 position, then ticks every 3 cycles. Other channels are unaffected.
- Write ch2 `div`=0, then `div`=7 after it idles → one final tick, then silence. After the second write, `pend[2]`=0 and the first tick comes 7 edges later.
- Write timed exactly at a ch0 boundary with `div`=2 → the tick fires that edge, `pend[0]` never rises, and the next tick is 2 cycles later.
- `sync` pulse with ch3 `pend`=1 (`shd`=4) plus a simultaneous write ch0 `div`=6 → all ticks suppressed that cycle. Ch3 then ticks 4 edges later and ch0 6 edges later, with `pend` all 0.
- `cfg_chan`=4 with CHANNELS=4 (CHW=3 build) → `cfg_ack`=`cfg_err`=1 for one cycle and no channel changes. Also: `reset` asserted mid-period clears `tick`/`cnt` immediately.
